// File: rtl/weight_load_receiver_pkg.sv
// rtl/weight_load_receiver_pkg.sv - shared layer codes, FSM encoding and layer-size helper
package weight_load_receiver_pkg;

  // Layer select codes carried on i_weight_layer
  localparam logic [1:0] LAYER_NONE = 2'b00;
  localparam logic [1:0] LAYER_H1   = 2'b01;
  localparam logic [1:0] LAYER_H2   = 2'b10;
  localparam logic [1:0] LAYER_OUT  = 2'b11;

  // Load FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_L1 = 3'd1;
  localparam logic [2:0] ST_LOAD_L2 = 3'd2;
  localparam logic [2:0] ST_LOAD_L3 = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Words in a fully connected layer: one weight per input plus a trailing bias per node
  function automatic int unsigned layer_size(input int unsigned nodes, input int unsigned fan_in);
    return nodes * (fan_in + 1);
  endfunction

endpackage

// File: rtl/weight_layer_decode.sv
// rtl/weight_layer_decode.sv - per-layer size, write-enable and legality decode
module weight_layer_decode
  import weight_load_receiver_pkg::*;
#(
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic [LAYER_WIDTH-1:0]          layer_i,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] size_o,
  output logic [2:0]                      wr_en_o,
  output logic                            legal_o
);

  localparam int unsigned L1_WORDS = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE);
  localparam int unsigned L2_WORDS = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1);
  localparam int unsigned L3_WORDS = layer_size(NUMBER_OF_OUTPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_2);

  // Map a layer code to its word count and RAM select; code 00 selects nothing
  always_comb begin
    size_o  = '0;
    wr_en_o = 3'b000;
    legal_o = 1'b0;
    case (layer_i)
      LAYER_WIDTH'(LAYER_H1): begin
        size_o  = WEIGHT_COUNTER_WIDTH'(L1_WORDS);
        wr_en_o = 3'b001;
        legal_o = 1'b1;
      end
      LAYER_WIDTH'(LAYER_H2): begin
        size_o  = WEIGHT_COUNTER_WIDTH'(L2_WORDS);
        wr_en_o = 3'b010;
        legal_o = 1'b1;
      end
      LAYER_WIDTH'(LAYER_OUT): begin
        size_o  = WEIGHT_COUNTER_WIDTH'(L3_WORDS);
        wr_en_o = 3'b100;
        legal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/weight_load_receiver.sv
// rtl/weight_load_receiver.sv - in-order weight stream checker and RAM write generator
module weight_load_receiver
  import weight_load_receiver_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_weight_valid,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
  input  logic [DATA_WIDTH-1:0]           i_weight,
  output logic [2:0]                      o_wr_en,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]           o_wr_data,
  output logic                            o_load_busy,
  output logic                            o_load_done,
  output logic                            o_load_error
);

  localparam int CW = WEIGHT_COUNTER_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            wr_en_q, wr_en_d;
  logic [CW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [CW-1:0]          dec_size;
  logic [2:0]             dec_en;
  logic                   dec_legal;
  logic [LAYER_WIDTH-1:0] cur_layer;
  logic                   in_load;
  logic                   start_beat;
  logic                   seq_beat;
  logic [CW-1:0]          cnt_inc;

  weight_layer_decode #(
    .LAYER_WIDTH                   (LAYER_WIDTH),
    .WEIGHT_COUNTER_WIDTH          (WEIGHT_COUNTER_WIDTH),
    .NUMBER_OF_INPUT_NODE          (NUMBER_OF_INPUT_NODE),
    .NUMBER_OF_HIDDEN_NODE_LAYER_1 (NUMBER_OF_HIDDEN_NODE_LAYER_1),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2 (NUMBER_OF_HIDDEN_NODE_LAYER_2),
    .NUMBER_OF_OUTPUT_NODE         (NUMBER_OF_OUTPUT_NODE)
  ) u_decode (
    .layer_i (i_weight_layer),
    .size_o  (dec_size),
    .wr_en_o (dec_en),
    .legal_o (dec_legal)
  );

  // Layer code the FSM is currently waiting for (00 outside a load)
  always_comb begin
    cur_layer = LAYER_WIDTH'(LAYER_NONE);
    case (state_q)
      ST_LOAD_L1: cur_layer = LAYER_WIDTH'(LAYER_H1);
      ST_LOAD_L2: cur_layer = LAYER_WIDTH'(LAYER_H2);
      ST_LOAD_L3: cur_layer = LAYER_WIDTH'(LAYER_OUT);
      default:    ;
    endcase
  end

  assign in_load = (state_q == ST_LOAD_L1) || (state_q == ST_LOAD_L2) || (state_q == ST_LOAD_L3);
  assign cnt_inc = cnt_q + CW'(1);

  // A (H1, 0) beat always (re)starts; inside a load it only counts as in-order if the counter matches
  assign start_beat = i_weight_valid && (i_weight_layer == LAYER_WIDTH'(LAYER_H1)) && (i_weight_addr == '0)
                      && !(in_load && (i_weight_layer == cur_layer) && (cnt_q == '0));
  assign seq_beat   = i_weight_valid && in_load && dec_legal && (i_weight_layer == cur_layer)
                      && (i_weight_addr == cnt_q) && (cnt_q < dec_size);

  // Next-state: accept/restart/reject decision, counter advance and layer stepping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    wr_en_d   = 3'b000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_beat) begin
      state_d   = ST_LOAD_L1;
      cnt_d     = CW'(1);
      busy_d    = 1'b1;
      done_d    = 1'b0;
      err_d     = in_load;
      wr_en_d   = dec_en;
      wr_addr_d = i_weight_addr;
      wr_data_d = i_weight;
    end else if (seq_beat) begin
      wr_en_d   = dec_en;
      wr_addr_d = i_weight_addr;
      wr_data_d = i_weight;
      if (cnt_inc == dec_size) begin
        cnt_d = '0;
        case (state_q)
          ST_LOAD_L1: state_d = ST_LOAD_L2;
          ST_LOAD_L2: state_d = ST_LOAD_L3;
          ST_LOAD_L3: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (i_weight_valid) begin
      err_d = 1'b1;
    end
  end

  // State registers; rst_n is active-high here
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 3'b000;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_load_busy  = busy_q;
  assign o_load_done  = done_q;
  assign o_load_error = err_q;

endmodule

// File: tb/tb_weight_load_receiver.sv
// tb/tb_weight_load_receiver.sv - directed self-checking bench for weight_load_receiver
module tb_weight_load_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_weight_valid = 1'b0;
  logic [1:0]  i_weight_layer = 2'b00;
  logic [10:0] i_weight_addr = '0;
  logic [31:0] i_weight = '0;
  logic [2:0]  o_wr_en;
  logic [10:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_load_busy;
  logic        o_load_done;
  logic        o_load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;
  bit use_gap  = 1'b0;

  weight_load_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_weight_valid (i_weight_valid),
    .i_weight_layer (i_weight_layer),
    .i_weight_addr  (i_weight_addr),
    .i_weight       (i_weight),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_load_busy    (o_load_busy),
    .o_load_done    (o_load_done),
    .o_load_error   (o_load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] lay);
    case (lay)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] pat(input int a);
    return use_gap ? (32'hA5A5_0000 | 32'(a)) : 32'(a);
  endfunction

  // One beat presented for one cycle; the write is checked right after the capturing edge
  task automatic beat(input logic [1:0] lay, input int a, input logic [31:0] d, input bit acc);
    @(negedge clk);
    i_weight_valid = 1'b1;
    i_weight_layer = lay;
    i_weight_addr  = 11'(a);
    i_weight       = d;
    @(posedge clk);
    #1;
    chk("wr_en", {29'd0, o_wr_en}, acc ? {29'd0, onehot(lay)} : 32'd0);
    if (acc) begin
      chk("wr_addr", {21'd0, o_wr_addr}, 32'(a));
      chk("wr_data", o_wr_data, d);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_weight_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_wr_en", {29'd0, o_wr_en}, 32'd0);
    end
  endtask

  // In-order beats [from, to) of one layer, with optional 3-cycle gap every 10 beats
  task automatic load_range(input logic [1:0] lay, input int from, input int to);
    for (int a = from; a < to; a++) begin
      if (use_gap && beat_cnt != 0 && (beat_cnt % 10) == 0) idle(3);
      beat(lay, a, pat(a), 1'b1);
      beat_cnt++;
    end
  endtask

  task automatic full_load();
    beat_cnt = 0;
    load_range(2'b01, 0, 96);
    chk("busy_mid_load", {31'd0, o_load_busy}, 32'd1);
    load_range(2'b10, 0, 1056);
    load_range(2'b11, 0, 99);
    chk("done_after_last", {31'd0, o_load_done}, 32'd1);
    chk("busy_after_last", {31'd0, o_load_busy}, 32'd0);
    chk("err_after_load", {31'd0, o_load_error}, 32'd0);
    chk("beats_written", 32'(beat_cnt), 32'd1251);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, {29'd0, o_wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {21'd0, o_wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, o_wr_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_load_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, o_load_error}, 32'd0);
  endtask

  initial begin
    // Reset coinciding with a valid start beat: reset wins, nothing written
    @(negedge clk);
    rst_n = 1'b1;
    i_weight_valid = 1'b1;
    i_weight_layer = 2'b01;
    i_weight_addr  = '0;
    i_weight       = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b0;
    i_weight_valid = 1'b0;
    idle(2);

    // Back-to-back full load, data = address
    use_gap = 1'b0;
    full_load();
    idle(2);
    chk("done_holds", {31'd0, o_load_done}, 32'd1);

    // Non-start beat in DONE is rejected and flags an error; done stays
    beat(2'b10, 0, 32'h1234_5678, 1'b0);
    chk("done_bad_err", {31'd0, o_load_error}, 32'd1);
    chk("done_bad_done", {31'd0, o_load_done}, 32'd1);

    // Gapped full load; the start beat clears the error
    use_gap = 1'b1;
    full_load();
    use_gap = 1'b0;
    idle(1);

    // Address mismatch inside LOAD_L2 at expected address 40
    beat(2'b01, 0, 32'd0, 1'b1);
    chk("restart_from_done_err", {31'd0, o_load_error}, 32'd0);
    load_range(2'b01, 1, 96);
    load_range(2'b10, 0, 40);
    beat(2'b10, 41, 32'h0000_0041, 1'b0);
    chk("mismatch_err", {31'd0, o_load_error}, 32'd1);
    beat(2'b10, 40, 32'd40, 1'b1);
    load_range(2'b10, 41, 1056);
    load_range(2'b11, 0, 99);
    chk("mismatch_done", {31'd0, o_load_done}, 32'd1);
    chk("mismatch_err_sticky", {31'd0, o_load_error}, 32'd1);
    idle(1);

    // Layer 00 in IDLE after reset, then a clean start
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset2");
    @(negedge clk);
    rst_n = 1'b0;
    beat(2'b00, 0, 32'h5555_AAAA, 1'b0);
    chk("layer0_err", {31'd0, o_load_error}, 32'd1);
    beat(2'b01, 0, 32'h0000_0000, 1'b1);
    chk("start_clr_err", {31'd0, o_load_error}, 32'd0);
    chk("start_busy", {31'd0, o_load_busy}, 32'd1);

    // Reset after 500 L2 beats abandons the load
    load_range(2'b01, 1, 96);
    load_range(2'b10, 0, 500);
    @(negedge clk);
    i_weight_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b0;
    beat(2'b10, 0, 32'h0000_0010, 1'b0);
    chk("after_reset_err", {31'd0, o_load_error}, 32'd1);
    chk("after_reset_busy", {31'd0, o_load_busy}, 32'd0);

    // Restart while in LOAD_L3
    beat(2'b01, 0, 32'd0, 1'b1);
    load_range(2'b01, 1, 96);
    load_range(2'b10, 0, 1056);
    load_range(2'b11, 0, 10);
    chk("l3_busy", {31'd0, o_load_busy}, 32'd1);
    chk("l3_err", {31'd0, o_load_error}, 32'd0);
    beat(2'b01, 0, 32'hCAFE_0000, 1'b1);
    chk("restart_err", {31'd0, o_load_error}, 32'd1);
    chk("restart_done", {31'd0, o_load_done}, 32'd0);
    chk("restart_busy", {31'd0, o_load_busy}, 32'd1);
    beat(2'b01, 1, 32'hCAFE_0001, 1'b1);
    beat(2'b10, 2, 32'hCAFE_0002, 1'b0);
    beat(2'b01, 3, 32'hCAFE_0003, 1'b0);
    beat(2'b01, 2, 32'hCAFE_0002, 1'b1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_load_receiver.md
WEIGHT_LOAD_RECEIVER -- requirements
Module: weight_load_receiver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 32, weight word width.
- LAYER_WIDTH, 2, layer-select width.
- WEIGHT_COUNTER_WIDTH, 11, address width.
- NUMBER_OF_INPUT_NODE, 2.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32.
- NUMBER_OF_OUTPUT_NODE, 3.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, synchronous, active-high reset (1 = reset).
- i_weight_valid, in, 1, input beat qualifier.
- i_weight_layer, in, LAYER_WIDTH, 01 = hidden1, 10 = hidden2, 11 = output.
- i_weight_addr, in, WEIGHT_COUNTER_WIDTH, flat word address within the layer.
- i_weight, in, DATA_WIDTH, weight word.
- o_wr_en, out, 3, one-hot RAM write enable: bit0 = hidden1, bit1 = hidden2, bit2 = output.
- o_wr_addr, out, WEIGHT_COUNTER_WIDTH, RAM address.
- o_wr_data, out, DATA_WIDTH, RAM data.
- o_load_busy, out, 1, a load is in progress.
- o_load_done, out, 1, all three layers are complete.
- o_load_error, out, 1, sticky protocol error.

Function
REQ-003 Layer sizes SHALL be:
- L1 = H1*(IN+1) = 96.
- L2 = H2*(H1+1) = 1056.
- L3 = OUT*(H2+1) = 99.
- Bias is the last word of each node.

REQ-004 The FSM SHALL have states IDLE, LOAD_L1, LOAD_L2, LOAD_L3, DONE.

REQ-005 An accepted beat SHALL produce exactly one write one cycle later: o_wr_en one-hot, o_wr_addr/o_wr_data registered copies of the input; o_wr_en is 0 in all other cycles.

REQ-006 A beat SHALL be accepted only when all of these hold:
- i_weight_valid = 1.
- i_weight_layer equals the current state's layer.
- i_weight_addr equals the per-layer expected counter.
- The counter is below the layer size.

REQ-007 IDLE/DONE: a valid beat with layer 01 and address 0 SHALL be accepted, enter LOAD_L1, set the counter to 1, clear o_load_done, and set o_load_busy.

REQ-008 On acceptance the counter SHALL increment. When it reaches the layer size, the counter SHALL clear and the FSM SHALL advance on that same edge: LOAD_L1 to LOAD_L2, LOAD_L2 to LOAD_L3, LOAD_L3 to DONE.

REQ-009 Entering DONE SHALL set o_load_done = 1 and o_load_busy = 0. o_load_done SHALL hold until reset or a new load start.

REQ-010 Gaps are legal: a cycle with i_weight_valid = 0 SHALL leave all state unchanged.

REQ-011 A valid beat that is not accepted SHALL:
- be dropped (no write);
- set o_load_error;
- leave state and counter unchanged.
Covered cases: layer 00, wrong layer, address mismatch, and any beat in IDLE/DONE other than (01, addr 0).

REQ-012 A new load start (REQ-007) SHALL clear o_load_error. Otherwise o_load_error SHALL stay set.

REQ-013 A start beat (01, addr 0) arriving while in LOAD_L1/L2/L3 SHALL restart the load at LOAD_L1 with counter 1, write the word, and set o_load_error (previous load aborted).

REQ-014 Address arithmetic SHALL be WEIGHT_COUNTER_WIDTH bits unsigned with no wrap-around. Max value 1055 fits in 11 bits.

Reset
REQ-015 While rst_n = 1 at a clk edge, the block SHALL set:
- state IDLE, counter 0;
- o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0;
- o_load_busy = 0, o_load_done = 0, o_load_error = 0.

REQ-016 A reset mid-load SHALL abandon the load. Subsequent beats are checked per REQ-007/REQ-011.

REQ-017 When reset and i_weight_valid coincide, reset SHALL win and no write SHALL occur.

Structure
REQ-018 A shared package SHALL hold:
- the layer codes (LAYER_NONE, LAYER_H1, LAYER_H2, LAYER_OUT);
- the FSM state encoding;
- layer-size constant functions derived from the node-count parameters.

REQ-019 Per-layer size selection and range check SHALL live in one combinational sub-module, weight_layer_decode (inputs: layer code; outputs: size, one-hot enable, legal flag). The FSM and counter SHALL stay in weight_load_receiver.

Verification
REQ-020 Full in-order load of 96 + 1056 + 99 beats, back-to-back, data = address -> the bench SHALL check:
- 1251 writes, each one cycle after its beat, with correct one-hot enables;
- o_load_done = 1 one cycle after the last beat;
- o_load_error = 0.

REQ-021 Same stream with a 3-cycle gap every 10 beats -> identical writes; done asserts one cycle after the final beat.

REQ-022 In LOAD_L2 at expected address 40, send address 41 -> no write, o_load_error = 1. Then send 40 -> write occurs and the load completes; error remains 1.

REQ-023 Beat with layer 00 in IDLE -> no write, error = 1. Then a valid (01, 0) start -> error = 0, busy = 1.

REQ-024 Assert rst_n after 500 L2 beats -> all outputs 0 next cycle. A following (10, 0) beat -> no write, error = 1.

REQ-025 Restart (01, 0) during LOAD_L3 -> hidden1 write at address 0, state LOAD_L1, error = 1, done = 0.
